// File: rtl/step_counter_fsm.sv
// Loadable step counter with programmable step/limit, wrap or saturate, and a
// start/busy/done handshake. Optional en prescaler: STEP_COUNTER_PRESCALE_EN.
module step_counter_fsm #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_data_in,
  input  logic              i_start,
  input  logic              i_en,
  input  logic              i_up_down,
  input  logic              i_mode,
  input  logic [STEP_W-1:0] i_step,
  input  logic [WIDTH-1:0]  i_limit,
  output logic [WIDTH-1:0]  o_data_out,
  output logic              o_c_end,
  output logic              o_tc_pulse,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_cnt;
  logic               r_tc;
  logic               r_busy;
  logic               r_done;

  logic [STEP_W-1:0]  w_step_eff;
  logic [WIDTH:0]     w_s;
  logic [WIDTH:0]     w_cnt_x;
  logic [WIDTH:0]     w_lim_x;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_tgt;
  logic [WIDTH-1:0]   w_wrap_val;
  logic [WIDTH-1:0]   w_stepped;
  logic               w_at_tgt;
  logic               w_hit;
  logic               w_tick;
  logic               w_start_ok;

  if (PRESCALE < 1 || STEP_W > WIDTH || WIDTH < 2) begin : g_bad_cfg
  end

  // One extra bit keeps count + step from silently wrapping before compare.
  assign w_step_eff = (i_step == '0) ? STEP_W'(1) : i_step;
  assign w_s        = {{(WIDTH+1-STEP_W){1'b0}}, w_step_eff};
  assign w_cnt_x    = {1'b0, r_cnt};
  assign w_lim_x    = {1'b0, i_limit};
  assign w_sum      = w_cnt_x + w_s;
  assign w_tgt      = i_up_down ? i_limit : '0;
  assign w_wrap_val = i_up_down ? '0 : i_limit;
  assign w_at_tgt   = (r_cnt == w_tgt);
  assign w_hit      = i_up_down ? ((w_sum >= w_lim_x) || (w_cnt_x >= w_lim_x))
                                : (w_cnt_x <= w_s);
  assign w_stepped  = i_up_down ? w_sum[WIDTH-1:0] : (r_cnt - w_s[WIDTH-1:0]);
  assign w_start_ok = i_start && (r_state != S_RUN);

`ifdef STEP_COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] r_presc;
  logic          w_presc_last;

  assign w_presc_last = (r_presc == PW'(PRESCALE-1));
  assign w_tick       = i_en && w_presc_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_presc <= '0;
    else if (i_load || w_start_ok || r_state != S_RUN)
      r_presc <= '0;
    else if (i_en)
      r_presc <= w_presc_last ? '0 : r_presc + PW'(1);
  end
`else
  assign w_tick = i_en;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_state <= S_IDLE;
      r_tc    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (i_load) begin
        r_cnt <= i_data_in;
        if (w_start_ok) begin
          r_state <= S_RUN;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end else if (r_state == S_DONE) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      end else if (w_start_ok) begin
        r_state <= S_RUN;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end else if (r_state == S_RUN && w_tick) begin
        if (w_at_tgt) begin
          // Already parked on the target: wrap restarts, saturate finishes.
          if (i_mode) begin
            r_cnt <= w_wrap_val;
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_tc    <= 1'b1;
          end
        end else if (w_hit) begin
          r_cnt <= w_tgt;
          r_tc  <= 1'b1;
          if (!i_mode) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end else begin
          r_cnt <= w_stepped;
        end
      end
    end
  end

  assign o_data_out = r_cnt;
  assign o_c_end    = w_at_tgt;
  assign o_tc_pulse = r_tc;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: doc/step_counter_fsm.md
Name: step_counter_fsm

Overview:
- Parametrised successor to the multiplier's loadable up/down iteration counter.
- Adds programmable step, programmable up-count limit, wrap/saturate mode and a start/busy/done handshake.
- Lets the shift-add datapath and future sequenced blocks run an iteration count without external glue.
- Sits between the multiplier control FSM and the datapath; its terminal-count outputs gate the shift/add sequencing.

Parameters:
- WIDTH, 8, count/limit/data width in bits (>=2).
- STEP_W, 4, step input width in bits (1..WIDTH).
- PRESCALE, 4, en pulses per count step; used only with STEP_COUNTER_PRESCALE_EN (>=1).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  parallel load of data_in into count, any state.
- data_in  in  WIDTH  load value.
- start  in  1  begin run (IDLE or DONE -> RUN).
- en  in  1  count enable, honoured only in RUN.
- up_down  in  1  1 = count up toward limit; 0 = count down toward 0.
- mode  in  1  0 = saturate and finish at target; 1 = wrap and keep running.
- step  in  STEP_W  increment magnitude; 0 is treated as 1.
- limit  in  WIDTH  up-count target.
- data_out  out  WIDTH  current count register.
- c_end  out  1  combinational: count == target (target = up_down ? limit : 0).
- tc_pulse  out  1  registered, 1 cycle: count reached target on the previous edge.
- busy  out  1  state == RUN.
- done  out  1  state == DONE (level).

Behaviour:
- Reset (async) values: count = 0, state = IDLE, tc_pulse = 0, busy = 0, done = 0, prescaler = 0. c_end follows its combinational equation.
- Clock: asynchronous, active-high reset rst; clock clk.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --saturate hit--> DONE.
  - DONE --start--> RUN.
  - DONE --load (without start)--> IDLE.
  - RUN ignores start.
- Priority per edge: load > start > en.
  - load writes count = data_in and clears the prescaler.
  - If start is also high in IDLE/DONE, state -> RUN, but no step is taken on that edge.
- Counting happens only in RUN with en = 1. Effective step s = (step == 0) ? 1 : step, zero-extended to WIDTH+1 bits.
- Arithmetic is WIDTH+1 bits, with no silent modular wrap:
  - Up: hit when count + s >= limit, or count >= limit (covers data_in > limit).
  - Down: hit when count <= s.
  - No hit: count +/- s.
- Hit while count != target: count <- target; tc_pulse = 1 on the next cycle.
  - mode = 0: state -> DONE on the same edge.
  - mode = 1: stay in RUN.
- Wrap (mode = 1), step taken while count == target: count <- opposite endpoint (up: 0; down: limit), no tc_pulse, stay in RUN.
- Saturate (mode = 0), RUN entered with count already == target: first enabled step sets state -> DONE and tc_pulse = 1; count unchanged.
- Edge values:
  - limit = 0 with up counting: target is 0, the same behaviour as above.
  - up_down and limit are sampled every cycle; changing them mid-run retargets immediately.
- Latency: an en pulse updates data_out one cycle later; tc_pulse and done are both visible the cycle after the hitting edge.
- Reset mid-RUN: immediate return to the reset values; no tc_pulse is emitted.

Optional Feature:
- Macro: STEP_COUNTER_PRESCALE_EN.
- Defined: an internal prescaler counts en pulses in RUN. A step is taken only on the PRESCALE-th pulse, after which the prescaler returns to 0.
  - The prescaler is cleared by rst, load, start and any RUN exit.
  - With PRESCALE = 1 the behaviour is identical to the undefined build.
- Undefined: every en pulse in RUN takes a step; the PRESCALE parameter is ignored; no prescaler logic.

Test Plan:
- Reset: after rst pulse -> data_out = 0, busy = 0, done = 0, tc_pulse = 0, c_end = 1 with up_down = 0.
- Down saturate: load 5, start, up_down = 0, mode = 0, step = 2, en held -> data_out 5, 3, 1, 0; done = 1 and tc_pulse = 1 on the cycle data_out = 0; further en leaves 0.
- Up wrap: load 0, limit = 6, step = 4, mode = 1, start, en held -> data_out 0, 4, 6 (tc_pulse), 0, 4, 6 (tc_pulse); busy stays 1.
- Priority: in RUN with count = 3, assert load (data_in = 9) + en together -> data_out = 9, no step; in DONE, load + start -> count = data_in, state RUN.
- Reset mid-run: at count = 4 in RUN, assert rst asynchronously mid-cycle -> data_out = 0 and busy = 0 immediately, no tc_pulse.
- Prescale (macro defined, PRESCALE = 3): load 6, step 1, down, start, en held 9 cycles -> data_out 6, 6, 5, 5, 5, 4, ... i.e. one step per 3 en pulses.
